// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory responder for the IF (port 0) and MEM (port 1)
// requestors. Owns the on-chip byte RAM, arbitrates ownership with a
// three-state FSM (MEM has priority from IDLE), and returns read bytes
// through a one-cycle output register.
//
// Optional feature: define MEM_CTRL_IO_EN to map a single byte-wide I/O port
// at IO_ADDR on the MEM side (io_wr_o / io_dout_o / io_din_i).
//
// Parameters:
//   ADDR_W   RAM address width, RAM holds 2**ADDR_W bytes
//   IO_ADDR  byte address of the I/O port
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   if_req_i     IF request, held for the whole burst
//   if_addr_i    IF byte address
//   if_gnt_o     IF owns the RAM this cycle (combinational)
//   if_data_o    registered read byte for IF
//   mem_req_i    MEM request, held for the whole burst
//   mem_addr_i   MEM byte address
//   mem_we_i     MEM write enable (1 = store)
//   mem_wdata_i  MEM store byte
//   mem_gnt_o    MEM owns the RAM this cycle (combinational)
//   mem_data_o   registered read byte for MEM
//   io_wr_o      one-cycle I/O write strobe        (MEM_CTRL_IO_EN only)
//   io_dout_o    I/O write byte                    (MEM_CTRL_IO_EN only)
//   io_din_i     I/O read byte                     (MEM_CTRL_IO_EN only)
module mem_ctrl #(
    parameter int unsigned ADDR_W  = 17,
    parameter logic [31:0] IO_ADDR = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic [7:0]  if_data_o,
    input  logic        mem_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_we_i,
    input  logic [7:0]  mem_wdata_i,
    output logic        mem_gnt_o,
    output logic [7:0]  mem_data_o
`ifdef MEM_CTRL_IO_EN
    ,
    output logic        io_wr_o,
    output logic [7:0]  io_dout_o,
    input  logic [7:0]  io_din_i
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_IF,
        OWN_MEM
    } state_t;

    state_t state, state_nxt;

    logic [7:0] ram [2**ADDR_W];

    logic if_io, mem_io;
    logic if_in_ram, mem_in_ram;

    // IO_ADDR never maps onto RAM; without the I/O feature it simply behaves
    // as an out-of-range address.
    assign if_io      = (if_addr_i == IO_ADDR);
    assign mem_io     = (mem_addr_i == IO_ADDR);
    assign if_in_ram  = (if_addr_i[31:ADDR_W] == '0) && !if_io;
    assign mem_in_ram = (mem_addr_i[31:ADDR_W] == '0) && !mem_io;

    // Grants are forced low while reset is asserted so a write presented on
    // the reset edge cannot reach the RAM.
    always_comb begin
        state_nxt = state;
        if_gnt_o  = 1'b0;
        mem_gnt_o = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    mem_gnt_o = mem_req_i;
                    if_gnt_o  = if_req_i & ~mem_req_i;
                    if (mem_req_i)
                        state_nxt = OWN_MEM;
                    else if (if_req_i)
                        state_nxt = OWN_IF;
                end
                OWN_IF: begin
                    if_gnt_o = if_req_i;
                    if (!if_req_i)
                        state_nxt = IDLE;
                end
                OWN_MEM: begin
                    mem_gnt_o = mem_req_i;
                    if (!mem_req_i)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_gnt_o && mem_we_i && mem_in_ram)
            ram[mem_addr_i[ADDR_W-1:0]] <= mem_wdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            if_data_o  <= '0;
            mem_data_o <= '0;
        end else begin
            state <= state_nxt;

            if (if_gnt_o) begin
                if (if_in_ram)
                    if_data_o <= ram[if_addr_i[ADDR_W-1:0]];
                else
                    if_data_o <= '0;
            end

            if (mem_gnt_o && !mem_we_i) begin
                if (mem_in_ram)
                    mem_data_o <= ram[mem_addr_i[ADDR_W-1:0]];
`ifdef MEM_CTRL_IO_EN
                else if (mem_io)
                    mem_data_o <= io_din_i;
`endif
                else
                    mem_data_o <= '0;
            end
        end
    end

`ifdef MEM_CTRL_IO_EN
    // Strobe lasts exactly the cycle after the write edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_wr_o   <= 1'b0;
            io_dout_o <= '0;
        end else begin
            io_wr_o <= mem_gnt_o & mem_we_i & mem_io;
            if (mem_gnt_o && mem_we_i && mem_io)
                io_dout_o <= mem_wdata_i;
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl. Inputs are driven on the falling edge; grants
// are checked combinationally before the rising edge and data outputs just
// after it. Read expectations come from a byte model and are queued when the
// access is driven, then popped when the registered byte appears.
module tb_mem_ctrl;

    localparam int unsigned AW   = 17;
    localparam logic [31:0] IO_A = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic [7:0]  if_data_o;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [7:0]  mem_wdata_i;
    logic        mem_gnt_o;
    logic [7:0]  mem_data_o;
`ifdef MEM_CTRL_IO_EN
    logic        io_wr_o;
    logic [7:0]  io_dout_o;
    logic [7:0]  io_din_i;
`endif

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(AW), .IO_ADDR(IO_A)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_gnt_o   (if_gnt_o),
        .if_data_o  (if_data_o),
        .mem_req_i  (mem_req_i),
        .mem_addr_i (mem_addr_i),
        .mem_we_i   (mem_we_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_gnt_o  (mem_gnt_o),
        .mem_data_o (mem_data_o)
`ifdef MEM_CTRL_IO_EN
        ,
        .io_wr_o    (io_wr_o),
        .io_dout_o  (io_dout_o),
        .io_din_i   (io_din_i)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] model [int unsigned];
    logic [7:0] mem_q [$];
    logic [7:0] if_q  [$];
    logic [7:0] mem_last = 8'h00;
    logic [7:0] if_last  = 8'h00;
    logic [7:0] io_dout_last = 8'h00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [31:0] a);
        if (a[31:AW] != '0)
            return 8'h00;
        if (model.exists(a[AW-1:0]))
            return model[a[AW-1:0]];
        return 8'h00;
    endfunction

    // One clock cycle: drive, check grants, queue expectations, then check
    // registered outputs after the edge. Called at a falling edge.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic mr, input logic [31:0] ma,
                        input logic we, input logic [7:0] wd,
                        input logic eig, input logic emg);
        logic [7:0] e;
        logic       io_w;
        if_req_i    = ir;
        if_addr_i   = ia;
        mem_req_i   = mr;
        mem_addr_i  = ma;
        mem_we_i    = we;
        mem_wdata_i = wd;
        #1;
        chk("if_gnt", {7'd0, if_gnt_o}, {7'd0, eig});
        chk("mem_gnt", {7'd0, mem_gnt_o}, {7'd0, emg});
        io_w = 1'b0;
        if (emg) begin
            if (we) begin
                if (ma[31:AW] == '0)
                    model[ma[AW-1:0]] = wd;
`ifdef MEM_CTRL_IO_EN
                if (ma == IO_A)
                    io_w = 1'b1;
`endif
            end else begin
                e = exp_rd(ma);
`ifdef MEM_CTRL_IO_EN
                if (ma == IO_A)
                    e = io_din_i;
`endif
                mem_q.push_back(e);
            end
        end
        if (eig)
            if_q.push_back(exp_rd(ia));
        @(posedge clk);
        #1;
        if (mem_q.size() > 0)
            mem_last = mem_q.pop_front();
        if (if_q.size() > 0)
            if_last = if_q.pop_front();
        chk("mem_data", mem_data_o, mem_last);
        chk("if_data", if_data_o, if_last);
`ifdef MEM_CTRL_IO_EN
        if (io_w)
            io_dout_last = wd;
        chk("io_wr", {7'd0, io_wr_o}, {7'd0, io_w});
        chk("io_dout", io_dout_o, io_dout_last);
`endif
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_gnt"}, {7'd0, if_gnt_o}, 8'h00);
        chk({tag, "_mem_gnt"}, {7'd0, mem_gnt_o}, 8'h00);
        chk({tag, "_if_data"}, if_data_o, 8'h00);
        chk({tag, "_mem_data"}, mem_data_o, 8'h00);
`ifdef MEM_CTRL_IO_EN
        chk({tag, "_io_wr"}, {7'd0, io_wr_o}, 8'h00);
        chk({tag, "_io_dout"}, io_dout_o, 8'h00);
`endif
    endtask

    initial begin
        // Reset with both requests asserted: nothing may be granted.
        rst         = 1'b0;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0;
        mem_req_i   = 1'b1;
        mem_addr_i  = 32'h0;
        mem_we_i    = 1'b0;
        mem_wdata_i = 8'h00;
`ifdef MEM_CTRL_IO_EN
        io_din_i    = 8'h5A;
`endif
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_reset_outputs("reset");
        end
        @(negedge clk);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        rst       = 1'b1;

        // MEM 4-byte store of DEADBEEF at 0x100, little-endian byte order.
        step(0, 0, 1, 32'h100, 1, 8'hEF, 0, 1);
        step(0, 0, 1, 32'h101, 1, 8'hBE, 0, 1);
        step(0, 0, 1, 32'h102, 1, 8'hAD, 0, 1);
        step(0, 0, 1, 32'h103, 1, 8'hDE, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);
        // 4-byte load, then read-after-write on consecutive bytes.
        step(0, 0, 1, 32'h100, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h101, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h102, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h103, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h104, 1, 8'h77, 0, 1);
        step(0, 0, 1, 32'h104, 0, 8'h00, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Preload 0x000..0x003 for the IF fetch.
        step(0, 0, 1, 32'h0, 1, 8'h11, 0, 1);
        step(0, 0, 1, 32'h1, 1, 8'h22, 0, 1);
        step(0, 0, 1, 32'h2, 1, 8'h33, 0, 1);
        step(0, 0, 1, 32'h3, 1, 8'h44, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Simultaneous requests: MEM for 2 cycles, one idle cycle, then IF.
        step(1, 32'h0, 1, 32'h100, 0, 8'h00, 0, 1);
        step(1, 32'h0, 1, 32'h101, 0, 8'h00, 0, 1);
        step(1, 32'h0, 0, 0, 0, 8'h00, 0, 0);
        step(1, 32'h0, 0, 0, 0, 8'h00, 1, 0);
        step(1, 32'h1, 0, 0, 0, 8'h00, 1, 0);
        step(1, 32'h2, 0, 0, 0, 8'h00, 1, 0);
        step(1, 32'h3, 0, 0, 0, 8'h00, 1, 0);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Locked grant: MEM rises mid IF fetch and waits.
        step(1, 32'h100, 0, 0, 0, 8'h00, 1, 0);
        step(1, 32'h101, 0, 0, 0, 8'h00, 1, 0);
        step(1, 32'h102, 1, 32'h0, 0, 8'h00, 1, 0);
        step(1, 32'h103, 1, 32'h0, 0, 8'h00, 1, 0);
        step(0, 0, 1, 32'h0, 0, 8'h00, 0, 0);
        step(0, 0, 1, 32'h0, 0, 8'h00, 0, 1);
        // Same owner drops and re-raises: one idle cycle, then re-grant.
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 1, 32'h1, 0, 8'h00, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Boundaries and the I/O address.
        step(0, 0, 1, 32'h1FFFF, 1, 8'hA5, 0, 1);
        step(0, 0, 1, 32'h20000, 1, 8'h5C, 0, 1);
        step(0, 0, 1, 32'h1FFFF, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h20000, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h0, 0, 8'h00, 0, 1);
        step(0, 0, 1, IO_A, 1, 8'h41, 0, 1);
        step(0, 0, 1, IO_A, 0, 8'h00, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);
        // IF reads of out-of-range and I/O addresses return zero.
        step(1, 32'h20000, 0, 0, 0, 8'h00, 1, 0);
        step(1, 32'h1FFFF, 0, 0, 0, 8'h00, 1, 0);
        step(1, IO_A, 0, 0, 0, 8'h00, 1, 0);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Reset mid-burst: the write presented on the reset edge is lost.
        step(0, 0, 1, 32'h101, 1, 8'hC3, 0, 1);
        mem_req_i   = 1'b1;
        mem_addr_i  = 32'h102;
        mem_we_i    = 1'b1;
        mem_wdata_i = 8'hF0;
        rst         = 1'b0;
        #1;
        mem_last     = 8'h00;
        if_last      = 8'h00;
        io_dout_last = 8'h00;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst_edge");
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 1, 32'h102, 0, 8'h00, 0, 1);
        step(0, 0, 1, 32'h101, 0, 8'h00, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
